gray_cnt_tx: RTL and testbench
==============================

// Module: gray_cnt_tx
// PURPOSE
//  Gray-code counter/transmitter: the producing end of a Gray-coded value stream whose consumer decodes with gray2bin.
//  Keeps a binary count, steps it up or down on request and presents each new value as a registered Gray code.
//  A valid/ready handshake provides backpressure. Used for position/pointer streams that must change 1 bit per step.
// PARAMETERS
//  WIDTH      4  count and code width in bits (>=2)
//  RESET_VAL  0  binary count value loaded at reset (WIDTH bits)
// PORTS
//  clk_i          in   1      single clock, all logic on rising edge
//  rst_i          in   1      synchronous, active-high reset
//  en_i           in   1      step request, held until accepted
//  dir_i          in   1      1 = count up, 0 = count down (sampled with en_i)
//  load_i         in   1      load request, held until accepted
//  load_val_i     in   WIDTH  binary value to load
//  out_valid_o    out  1      out_gray_o holds an unconsumed code
//  out_ready_i    in   1      consumer accepts the code this cycle
//  out_gray_o     out  WIDTH  Gray code of the current count
//  wrap_o         out  1      qualifies out_gray_o: this code came from a wrap-around step
// BEHAVIOUR
//  Reset (rst_i=1 at a clock edge): bin_cnt=RESET_VAL, out_gray_o=0, out_valid_o=0, wrap_o=0, FSM=S_EMPTY.
//   Reset mid-operation drops any pending code. A held en_i/load_i is treated as a new request after reset.
//  Slot free: free = !out_valid_o || out_ready_i.
//   A request is accepted only when free=1. A code and its counter step can move in the same cycle.
//  Priority: load_i beats en_i. Both high and free -> only the load happens; en_i stays pending.
//  Load accepted: bin_cnt<=load_val_i; out_gray_o<=load_val_i^(load_val_i>>1); out_valid_o<=1; wrap_o<=0.
//  Step accepted: bin_nxt=bin_cnt+1 (dir_i=1) or bin_cnt-1 (dir_i=0), modulo 2^WIDTH.
//   bin_cnt<=bin_nxt; out_gray_o<=gray(bin_nxt); out_valid_o<=1.
//   wrap_o<=1 if up from all-ones or down from zero, else 0.
//  Latency: 1 cycle from accepted request to new code on out_gray_o.
//   Sustained throughput is 1 code/cycle while out_ready_i=1.
//  Stall: out_valid_o=1 and out_ready_i=0 -> out_gray_o, wrap_o and bin_cnt hold. Requests are not accepted.
//  Consume with no new request: out_valid_o<=0. out_gray_o and wrap_o hold their last value (don't-care while invalid).
//  FSM (2 states):
//   S_EMPTY -> S_FULL on an accepted load or step.
//   S_FULL stays in S_FULL on consume plus a new request.
//   S_FULL -> S_EMPTY on consume with no request.
//   out_valid_o = (state==S_FULL).
//  Arithmetic: all math is WIDTH-bit unsigned with natural wrap. No saturation.
// CONFIGURATION
//  Macro GRAY_CNT_TX_STEP_CHECK_EN:
//   Defined: adds output err_o (1 bit, reset 0), sticky until rst_i.
//    Set 1 cycle after a step-produced code is registered if it differs from the previous code in !=1 bit.
//    Codes following a load or reset are not checked.
//   Undefined: no err_o port and no check logic. All other behaviour is identical.
// STRUCTURE
//  gray_pkg (shared): function bin2gray_f(logic [WIDTH-1:0]); typedef enum logic {S_EMPTY,S_FULL} gray_tx_state_t.
//  Sub-module gray_step_check (instantiated only under GRAY_CNT_TX_STEP_CHECK_EN):
//   inputs prev/curr code plus a check qualifier; popcount(prev^curr)!=1 -> error pulse.
//  Top holds the counter, the output register and the FSM.
// TESTING (WIDTH=4, RESET_VAL=0)
//  1. Reset, en_i=1, dir_i=1, out_ready_i=1 for 3 cycles
//     -> out_gray_o 0001,0011,0010 on consecutive cycles, out_valid_o=1, wrap_o=0.
//  2. load_i with load_val_i=15, then one up step
//     -> out_gray_o 1000 (wrap_o=0), then 0000 with wrap_o=1.
//     From reset, one down step -> 1000 with wrap_o=1.
//  3. load_i=1, load_val_i=5, en_i=1 in the same cycle
//     -> out_gray_o=0111 first; next cycle the up step gives 0101 (bin 6).
//  4. out_ready_i=0 for 4 cycles with en_i=1 -> out_gray_o/bin_cnt hold, out_valid_o=1.
//     Raise out_ready_i -> one code per cycle resumes, no code skipped.
//  5. rst_i pulsed while out_valid_o=1 and out_ready_i=0
//     -> next cycle out_valid_o=0, out_gray_o=0000, wrap_o=0.
//  6. GRAY_CNT_TX_STEP_CHECK_EN: 32 random up/down steps -> err_o stays 0.
//     Force a 2-bit-change code into the checker -> err_o=1 and stays 1 until rst_i.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-coded value stream (producer and step checker).
// bin2gray_f works on a wide container; callers zero-extend and keep their own low bits.
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    typedef enum logic {S_EMPTY, S_FULL} gray_tx_state_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray_f(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_step_check.sv
// Purpose: flags a qualified Gray code pair whose codes differ in other than exactly one bit.
// Latency: combinational error pulse; backpressure: none, the caller qualifies with chk_vld.
module gray_step_check #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev_code,
    input  logic [WIDTH-1:0] curr_code,
    input  logic             chk_vld,
    output logic             err_pulse
);

    assign err_pulse = chk_vld && ($countones(prev_code ^ curr_code) != 1);

endmodule

// File: rtl/gray_cnt_tx.sv
// Purpose: up/down binary counter presenting each new value as a registered Gray code (GRAY_CNT_TX_STEP_CHECK_EN adds sticky err_o).
// Latency: 1 cycle from accepted load/step to code; backpressure: requests wait while out_valid_o && !out_ready_i.
import gray_pkg::*;

module gray_cnt_tx #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_gray_o,
    output logic             wrap_o
`ifdef GRAY_CNT_TX_STEP_CHECK_EN
    ,
    output logic             err_o
`endif
);

    gray_tx_state_t         state_q;
    logic [WIDTH-1:0]       bin_cnt_q;
    logic [WIDTH-1:0]       out_gray_q;
    logic                   wrap_q;

    logic [WIDTH-1:0]       bin_nxt;
    logic                   wrap_nxt;
    logic                   free;
    logic                   load_acc;
    logic                   step_acc;
    logic [GRAY_MAX_W-1:0]  load_wide;
    logic [GRAY_MAX_W-1:0]  step_wide;
    logic [GRAY_MAX_W-1:0]  load_gw;
    logic [GRAY_MAX_W-1:0]  step_gw;
    logic                   unused_gray_hi;

    assign free     = (state_q == S_EMPTY) || out_ready_i;
    assign load_acc = free && load_i;
    // Load wins; a simultaneous step stays pending for a later cycle.
    assign step_acc = free && en_i && !load_i;

    always_comb begin
        bin_nxt   = dir_i ? bin_cnt_q + WIDTH'(1) : bin_cnt_q - WIDTH'(1);
        wrap_nxt  = dir_i ? (bin_cnt_q == '1) : (bin_cnt_q == '0);
        load_wide = '0;
        load_wide[WIDTH-1:0] = load_val_i;
        step_wide = '0;
        step_wide[WIDTH-1:0] = bin_nxt;
        load_gw   = bin2gray_f(load_wide);
        step_gw   = bin2gray_f(step_wide);
    end

    assign unused_gray_hi = ^{load_gw[GRAY_MAX_W-1:WIDTH], step_gw[GRAY_MAX_W-1:WIDTH]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_EMPTY;
            bin_cnt_q  <= RESET_VAL;
            out_gray_q <= '0;
            wrap_q     <= 1'b0;
        end else if (load_acc) begin
            state_q    <= S_FULL;
            bin_cnt_q  <= load_val_i;
            out_gray_q <= load_gw[WIDTH-1:0];
            wrap_q     <= 1'b0;
        end else if (step_acc) begin
            state_q    <= S_FULL;
            bin_cnt_q  <= bin_nxt;
            out_gray_q <= step_gw[WIDTH-1:0];
            wrap_q     <= wrap_nxt;
        end else if (out_ready_i) begin
            state_q    <= S_EMPTY;
        end
    end

    assign out_valid_o = (state_q == S_FULL);
    assign out_gray_o  = out_gray_q;
    assign wrap_o      = wrap_q;

`ifdef GRAY_CNT_TX_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_code_q;
    logic             ref_vld_q;
    logic             chk_q;
    logic             err_q;
    logic             err_pulse;

    // The first code after reset has no trusted predecessor; loads just re-anchor the reference.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_code_q <= '0;
            ref_vld_q   <= 1'b0;
            chk_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            chk_q <= step_acc && ref_vld_q;
            if (step_acc) begin
                prev_code_q <= out_gray_q;
            end
            if (load_acc || step_acc) begin
                ref_vld_q <= 1'b1;
            end
            err_q <= err_q | err_pulse;
        end
    end

    gray_step_check #(
        .WIDTH (WIDTH)
    ) u_chk (
        .prev_code (prev_code_q),
        .curr_code (out_gray_q),
        .chk_vld   (chk_q),
        .err_pulse (err_pulse)
    );

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_gray_cnt_tx.sv
// Scoreboarded bench for gray_cnt_tx at WIDTH=4, RESET_VAL=0.
module tb_gray_cnt_tx;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] g;
        logic         w;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         dir;
    logic         ld;
    logic [W-1:0] ld_val;
    logic         vld;
    logic         rdy;
    logic [W-1:0] gray;
    logic         wrap;
`ifdef GRAY_CNT_TX_STEP_CHECK_EN
    logic         err;
`endif

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    gray_cnt_tx #(
        .WIDTH     (W),
        .RESET_VAL (4'd0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .dir_i       (dir),
        .load_i      (ld),
        .load_val_i  (ld_val),
        .out_valid_o (vld),
        .out_ready_i (rdy),
        .out_gray_o  (gray),
        .wrap_o      (wrap)
`ifdef GRAY_CNT_TX_STEP_CHECK_EN
        ,
        .err_o       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] g, input logic w);
        sb.push_back({g, w});
    endtask

    // Monitor: every consumed code is matched against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && vld && rdy) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_code: got %b, expected no code", gray);
            end else begin
                e = sb.pop_front();
                check("code", gray, e.g);
                check("wrap", {3'b000, wrap}, {3'b000, e.w});
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; ld = 1'b0; ld_val = '0; rdy = 1'b1;
        cyc(2);
        check("reset_vld",  {3'b000, vld},  4'b0000);
        check("reset_gray", gray,           4'b0000);
        check("reset_wrap", {3'b000, wrap}, 4'b0000);
        rst = 1'b0;

        // Three up steps from reset.
        push(4'b0001, 1'b0); push(4'b0011, 1'b0); push(4'b0010, 1'b0);
        en = 1'b1; dir = 1'b1;
        cyc(3);
        en = 1'b0;
        cyc();

        // Load 15, then wrap up to 0.
        push(4'b1000, 1'b0);
        ld = 1'b1; ld_val = 4'd15;
        cyc();
        ld = 1'b0;
        push(4'b0000, 1'b1);
        en = 1'b1; dir = 1'b1;
        cyc();
        en = 1'b0;
        cyc();

        // From reset, one down step wraps to 15.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        push(4'b1000, 1'b1);
        en = 1'b1; dir = 1'b0;
        cyc();
        en = 1'b0;
        cyc();

        // Load and step together: load 5 first, then the held step gives 6.
        push(4'b0111, 1'b0); push(4'b0101, 1'b0);
        ld = 1'b1; ld_val = 4'd5; en = 1'b1; dir = 1'b1;
        cyc();
        ld = 1'b0;
        cyc();
        en = 1'b0;
        cyc();

        // Stall: step to 7 is accepted, then held for 4 cycles.
        rdy = 1'b0; en = 1'b1; dir = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            check("stall_gray", gray,           4'b0100);
            check("stall_vld",  {3'b000, vld},  4'b0001);
            check("stall_wrap", {3'b000, wrap}, 4'b0000);
            cyc();
        end
        push(4'b0100, 1'b0); push(4'b1100, 1'b0); push(4'b1101, 1'b0); push(4'b1111, 1'b0);
        rdy = 1'b1;
        cyc(3);
        en = 1'b0;
        cyc();

        // Reset while a code (bin 11) is stalled drops it.
        rdy = 1'b0; en = 1'b1; dir = 1'b1;
        cyc();
        en = 1'b0;
        check("prerst_vld",  {3'b000, vld}, 4'b0001);
        check("prerst_gray", gray,          4'b1110);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("postrst_vld",  {3'b000, vld},  4'b0000);
        check("postrst_gray", gray,           4'b0000);
        check("postrst_wrap", {3'b000, wrap}, 4'b0000);
        rdy = 1'b1;
        cyc();

`ifdef GRAY_CNT_TX_STEP_CHECK_EN
        begin
            logic [W-1:0] m;
            logic [W-1:0] g_now;
            logic         d;
            m = '0;
            for (int i = 0; i < 32; i++) begin
                d = 1'($urandom_range(0, 1));
                push(d ? m + 4'd1 ^ ((m + 4'd1) >> 1) : (m - 4'd1) ^ ((m - 4'd1) >> 1),
                     d ? (m == 4'd15) : (m == 4'd0));
                m = d ? m + 4'd1 : m - 4'd1;
                en = 1'b1; dir = d;
                cyc();
            end
            en = 1'b0;
            cyc(2);
            check("err_clean", {3'b000, err}, 4'b0000);
            g_now = m ^ (m >> 1);
            force dut.prev_code_q = g_now ^ 4'b0011;
            force dut.chk_q = 1'b1;
            cyc();
            release dut.prev_code_q;
            release dut.chk_q;
            check("err_set", {3'b000, err}, 4'b0001);
            cyc(3);
            check("err_sticky", {3'b000, err}, 4'b0001);
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            check("err_rst", {3'b000, err}, 4'b0000);
        end
`endif

        cyc(2);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d codes never seen, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
